// File: rtl/wb_arb_pkg.sv
// Shared constants for the Wishbone B3 RAM arbiter: cycle/burst type codes and FSM states.
package wb_arb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LIN     = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr_i, wrapping modulo NM.
module wb_arb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NM = 2,
    parameter int PW = 1
) (
    input  logic [NM-1:0] req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    int k;

    // Walk candidates from farthest to nearest so the nearest requester wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int i = NM - 1; i >= 0; i--) begin
            k = int'(ptr_i) + i;
            if (k >= NM) begin
                k = k - NM;
            end
            if (req_i[k]) begin
                idx_o   = PW'(k);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_ram_arb_b3.sv
// Round-robin Wishbone B3 arbiter: NM masters share one RAM slave, grant locked for a whole cyc.
// Optional bus watchdog is enabled by defining WB_ARB_WATCHDOG_EN.
module wb_ram_arb_b3
    import wb_arb_pkg::*;
#(
    parameter int dw          = 32,
    parameter int aw          = 32,
    parameter int NM          = 2,
    parameter int WDOG_CYCLES = 256
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [NM*aw-1:0] m_adr_i,
    input  logic [NM*dw-1:0] m_dat_i,
    input  logic [NM*4-1:0]  m_sel_i,
    input  logic [NM*3-1:0]  m_cti_i,
    input  logic [NM*2-1:0]  m_bte_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_we_i,
    output logic [dw-1:0]    m_dat_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [NM-1:0]    m_rty_o,
    output logic [aw-1:0]    s_adr_o,
    output logic [dw-1:0]    s_dat_o,
    output logic [3:0]       s_sel_o,
    output logic [2:0]       s_cti_o,
    output logic [1:0]       s_bte_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    input  logic [dw-1:0]    s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_rty_i
);

    localparam int PW = (NM > 1) ? $clog2(NM) : 1;

    arb_state_e    state_q;
    logic [PW-1:0] gnt_q;
    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] gnt_inc;
    logic [PW-1:0] pick_idx;
    logic          pick_vld;
    logic          own;
    logic          cyc_g;
    logic          stb_g;
    logic          wdog_fire;

    wb_arb_rr_pick #(
        .NM (NM),
        .PW (PW)
    ) u_pick (
        .req_i   (m_cyc_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    // Reset gates the slave side immediately so a mid-cycle reset never leaks a strobe.
    assign own     = (state_q == OWN) && !wb_rst_i;
    assign cyc_g   = m_cyc_i[gnt_q];
    assign stb_g   = m_stb_i[gnt_q];
    assign gnt_inc = (gnt_q == PW'(NM - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        s_adr_o = m_adr_i[int'(gnt_q) * aw +: aw];
        s_dat_o = m_dat_i[int'(gnt_q) * dw +: dw];
        s_sel_o = m_sel_i[int'(gnt_q) * 4 +: 4];
        s_cti_o = m_cti_i[int'(gnt_q) * 3 +: 3];
        s_bte_o = m_bte_i[int'(gnt_q) * 2 +: 2];
        s_cyc_o = own && cyc_g && !wdog_fire;
        s_stb_o = own && cyc_g && stb_g && !wdog_fire;
        s_we_o  = own && cyc_g && m_we_i[gnt_q];
        m_dat_o = s_dat_i;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (own) begin
            m_ack_o[gnt_q] = s_ack_i;
            m_err_o[gnt_q] = s_err_i | wdog_fire;
            m_rty_o[gnt_q] = s_rty_i;
        end
    end

`ifdef WB_ARB_WATCHDOG_EN
    localparam int WW = ($clog2(WDOG_CYCLES + 1) > 8) ? $clog2(WDOG_CYCLES + 1) : 8;

    logic [WW-1:0] wdog_q;
    logic          stb_raw;

    // Counts strobed cycles without a response; fires on the WDOG_CYCLES-th one.
    assign stb_raw   = own && cyc_g && stb_g;
    assign wdog_fire = stb_raw && (wdog_q == WW'(WDOG_CYCLES - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !stb_raw || s_ack_i || s_err_i || wdog_fire) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end
`else
    logic wdog_unused;

    assign wdog_fire   = 1'b0;
    assign wdog_unused = (WDOG_CYCLES != 0);
`endif

    // Grant is held until the owner drops cyc; releasing always passes through IDLE.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q   <= pick_idx;
                        state_q <= OWN;
                    end
                end
                OWN: begin
                    if (!cyc_g || wdog_fire) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= gnt_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ram_arb_b3.sv
// Bench for wb_ram_arb_b3: table of single transfers plus contention, burst, error and reset sequences.
module tb_wb_ram_arb_b3;
    import wb_arb_pkg::*;

    localparam int NM = 2;
    localparam int DW = 32;
    localparam int AW = 32;

    logic             clk;
    logic             rst;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat;
    logic [NM*4-1:0]  m_sel;
    logic [NM*3-1:0]  m_cti;
    logic [NM*2-1:0]  m_bte;
    logic [NM-1:0]    m_cyc;
    logic [NM-1:0]    m_stb;
    logic [NM-1:0]    m_we;
    logic [DW-1:0]    m_dat_rd;
    logic [NM-1:0]    m_ack;
    logic [NM-1:0]    m_err;
    logic [NM-1:0]    m_rty;
    logic [AW-1:0]    s_adr;
    logic [DW-1:0]    s_dat_wr;
    logic [3:0]       s_sel;
    logic [2:0]       s_cti;
    logic [1:0]       s_bte;
    logic             s_cyc;
    logic             s_stb;
    logic             s_we;
    logic [DW-1:0]    s_dat_q;
    logic             ack_q;
    logic             err_q;
    logic             stall_en;
    logic [31:0]      mem [256];

    wb_ram_arb_b3 #(
        .dw (DW), .aw (AW), .NM (NM), .WDOG_CYCLES (256)
    ) dut (
        .wb_clk_i (clk),    .wb_rst_i (rst),
        .m_adr_i  (m_adr),  .m_dat_i  (m_dat),    .m_sel_i (m_sel),
        .m_cti_i  (m_cti),  .m_bte_i  (m_bte),    .m_cyc_i (m_cyc),
        .m_stb_i  (m_stb),  .m_we_i   (m_we),     .m_dat_o (m_dat_rd),
        .m_ack_o  (m_ack),  .m_err_o  (m_err),    .m_rty_o (m_rty),
        .s_adr_o  (s_adr),  .s_dat_o  (s_dat_wr), .s_sel_o (s_sel),
        .s_cti_o  (s_cti),  .s_bte_o  (s_bte),    .s_cyc_o (s_cyc),
        .s_stb_o  (s_stb),  .s_we_o   (s_we),
        .s_dat_i  (s_dat_q), .s_ack_i (ack_q),    .s_err_i (err_q), .s_rty_i (1'b0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    // RAM slave: registered ack one cycle after strobe, err above 128 KiB, optional stall at 0x40.
    always @(posedge clk) begin
        ack_q <= 1'b0;
        err_q <= 1'b0;
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(32'(i * 4));
        end else if (s_cyc && s_stb && !ack_q && !err_q) begin
            if (s_adr >= 32'h0002_0000) begin
                err_q <= 1'b1;
            end else if (!(stall_en && s_adr == 32'h40)) begin
                ack_q   <= 1'b1;
                s_dat_q <= mem[s_adr[9:2]];
                if (s_we) mem[s_adr[9:2]] <= s_dat_wr;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] dat;
        bit          chk;
        bit          err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   ack_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int log_code();
        int c = 0;
        foreach (ack_log[i]) c = c * 16 + ack_log[i];
        return c;
    endfunction

    // Scoreboard: every response must be one-hot and match the owning master's oldest expectation.
    always @(negedge clk) begin
        logic [NM-1:0] hit;
        exp_t          e;
        int            m;
        hit = m_ack | m_err | m_rty;
        if (hit != '0) begin
            n_tests++;
            if (hit != 2'b01 && hit != 2'b10) begin
                n_fail++;
                $display("FAIL resp_onehot: got ack=%b err=%b, required exactly one master", m_ack, m_err);
            end else begin
                m = hit[1] ? 1 : 0;
                if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                    n_fail++;
                    $display("FAIL unexpected_resp m%0d: got ack=%b err=%b, required none", m, m_ack, m_err);
                end else begin
                    if (m == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    if (m_err[m] !== e.err || (e.chk && m_dat_rd !== e.dat)) begin
                        n_fail++;
                        $display("FAIL resp_m%0d: got dat=%h err=%0d, required dat=%h err=%0d",
                                 m, m_dat_rd, m_err[m], e.dat, e.err);
                    end
                end
                ack_log.push_back(m);
            end
        end
    end

    function automatic logic [31:0] beat_adr(input logic [31:0] a0, input logic [1:0] bte, input int b);
        logic [31:0] nxt;
        logic [31:0] mask;
        nxt = a0 + 32'(b * 4);
        case (bte)
            BTE_WRAP4:  mask = 32'h0F;
            BTE_WRAP8:  mask = 32'h1F;
            BTE_WRAP16: mask = 32'h3F;
            default:    return nxt;
        endcase
        return (a0 & ~mask) | (nxt & mask);
    endfunction

    // One master cycle: beats transfers, then hold cycles with cyc high and stb low.
    task automatic master_xfer(input int m, input logic [31:0] adr0, input logic we,
                               input logic [31:0] wd, input logic [31:0] exp_dat, input bit exp_err,
                               input int beats, input logic [1:0] bte, input int hold,
                               input int start_dly, output int lat);
        logic [31:0] adr;
        exp_t        e;
        int          cnt;
        bit          granted;
        bit          done;
        repeat (start_dly) @(posedge clk);
        @(posedge clk);
        #1;
        lat     = -1;
        cnt     = 0;
        granted = 1'b0;
        adr     = adr0;
        m_cyc[m] = 1'b1;
        m_we[m]  = we;
        m_sel[m*4 +: 4]   = 4'hF;
        m_bte[m*2 +: 2]   = bte;
        m_dat[m*DW +: DW] = wd;
        for (int b = 0; b < beats; b++) begin
            adr = beat_adr(adr0, bte, b);
            m_adr[m*AW +: AW] = adr;
            m_stb[m] = 1'b1;
            m_cti[m*3 +: 3] = (beats == 1) ? CTI_CLASSIC : ((b == beats - 1) ? CTI_END : CTI_INCR);
            e.dat = (beats == 1) ? exp_dat : init_val(adr);
            e.chk = !we && !exp_err;
            e.err = exp_err;
            if (m == 0) q0.push_back(e);
            else        q1.push_back(e);
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (!granted && s_cyc && s_adr == adr && s_we == we) begin
                    granted = 1'b1;
                    lat     = cnt;
                end
                cnt++;
                if (m_ack[m] || m_err[m]) begin
                    done = 1'b1;
                end else if (cnt > 600) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL timeout m%0d adr=%h: got no response, required ack/err", m, adr);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        m_stb[m] = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_cyc", 64'(s_cyc), 64'd1);
            check("hold_adr", 64'(s_adr), 64'(adr));
            @(posedge clk);
            #1;
        end
        m_cyc[m] = 1'b0;
        m_we[m]  = 1'b0;
    endtask

    typedef struct {
        int          m;
        logic [31:0] adr;
        logic        we;
        logic [31:0] wd;
        logic [31:0] exp_dat;
        bit          exp_err;
    } vec_t;

    vec_t vec[8];
    int   lat0;
    int   lat1;

    initial begin
        vec[0] = '{0, 32'h0000_0100, 1'b0, 32'h0,         32'hC0DE_0100, 1'b0};
        vec[1] = '{1, 32'h0000_0104, 1'b0, 32'h0,         32'hC0DE_0104, 1'b0};
        vec[2] = '{0, 32'h0000_0200, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vec[3] = '{1, 32'h0000_0200, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vec[4] = '{1, 32'h0000_03FC, 1'b1, 32'h1234_5678, 32'h0,         1'b0};
        vec[5] = '{0, 32'h0000_03FC, 1'b0, 32'h0,         32'h1234_5678, 1'b0};
        vec[6] = '{1, 32'h0002_0000, 1'b0, 32'h0,         32'h0,         1'b1};
        vec[7] = '{0, 32'h0000_0008, 1'b0, 32'h0,         32'hC0DE_0008, 1'b0};

        rst      = 1'b1;
        stall_en = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0; m_bte = '0;
        m_we  = '0; m_cyc = '1; m_stb = '1;

        // Reset with every master requesting: nothing reaches the slave or the masters.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_cyc", 64'(s_cyc), 64'd0);
        check("rst_s_stb", 64'(s_stb), 64'd0);
        check("rst_ack",   64'(m_ack | m_err | m_rty), 64'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        @(negedge clk);
        check("rst_gnt",    64'(dut.gnt_q), 64'd0);
        check("idle_s_cyc", 64'(s_cyc), 64'd0);

        // Simultaneous requests with ptr=0: m0 first, one IDLE cycle, then m1.
        ack_log.delete();
        fork
            master_xfer(0, 32'h10, 1'b0, 32'h0, 32'hC0DE_0010, 1'b0, 1, BTE_LIN, 0, 0, lat0);
            master_xfer(1, 32'h14, 1'b0, 32'h0, 32'hC0DE_0014, 1'b0, 1, BTE_LIN, 0, 0, lat1);
        join
        check("rr1_order", 64'(log_code()), 64'h01);
        check("rr1_lat_m0", 64'(lat0), 64'd1);
        check("rr1_lat_m1", 64'(lat1), 64'd5);
        ack_log.delete();
        fork
            master_xfer(0, 32'h18, 1'b0, 32'h0, 32'hC0DE_0018, 1'b0, 1, BTE_LIN, 0, 0, lat0);
            master_xfer(1, 32'h1C, 1'b0, 32'h0, 32'hC0DE_001C, 1'b0, 1, BTE_LIN, 0, 0, lat1);
        join
        check("rr2_order", 64'(log_code()), 64'h01);

        // Single requesters are always granted after one IDLE cycle.
        for (int i = 0; i < 8; i++) begin
            ack_log.delete();
            master_xfer(vec[i].m, vec[i].adr, vec[i].we, vec[i].wd, vec[i].exp_dat,
                        vec[i].exp_err, 1, BTE_LIN, 0, 0, lat0);
            check($sformatf("vec%0d_lat", i),   64'(lat0), 64'd1);
            check($sformatf("vec%0d_owner", i), 64'(log_code()), 64'(vec[i].m));
        end

        // Reset while m0 owns the bus.
        @(posedge clk);
        #1;
        m_cyc[0] = 1'b1;
        m_adr[0 +: AW] = 32'h80;
        repeat (3) @(negedge clk);
        check("own_s_cyc", 64'(s_cyc), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_s_cyc", 64'(s_cyc), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("postrst_idle", 64'(s_cyc), 64'd0);
        @(negedge clk);
        check("postrst_regrant", 64'(s_cyc), 64'd1);
        @(posedge clk);
        #1;
        m_cyc[0] = 1'b0;

        // Wrap-4 burst by m1 is never split by m0's request.
        ack_log.delete();
        fork
            master_xfer(1, 32'h1C, 1'b0, 32'h0, 32'h0, 1'b0, 4, BTE_WRAP4, 0, 0, lat1);
            master_xfer(0, 32'h30, 1'b0, 32'h0, 32'hC0DE_0030, 1'b0, 1, BTE_LIN, 0, 2, lat0);
        join
        check("burst_order", 64'(log_code()), 64'h11110);
        check("burst_lat_m1", 64'(lat1), 64'd1);

        // Slave error goes only to the owner; grant held while the owner keeps cyc.
        ack_log.delete();
        fork
            master_xfer(0, 32'h0002_0000, 1'b0, 32'h0, 32'h0, 1'b1, 1, BTE_LIN, 3, 0, lat0);
            master_xfer(1, 32'h24, 1'b0, 32'h0, 32'hC0DE_0024, 1'b0, 1, BTE_LIN, 0, 1, lat1);
        join
        check("err_order", 64'(log_code()), 64'h01);

`ifdef WB_ARB_WATCHDOG_EN
        // Stalled slave: the watchdog errors the owner once, then the other master runs.
        stall_en = 1'b1;
        ack_log.delete();
        fork
            master_xfer(0, 32'h40, 1'b0, 32'h0, 32'h0, 1'b1, 1, BTE_LIN, 0, 0, lat0);
            master_xfer(1, 32'h44, 1'b0, 32'h0, 32'hC0DE_0044, 1'b0, 1, BTE_LIN, 0, 2, lat1);
        join
        stall_en = 1'b0;
        check("wdog_order", 64'(log_code()), 64'h01);
`endif

        repeat (4) @(posedge clk);
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "bench timeout");
    end

endmodule
